// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder built from a replicated 1-bit
// full-adder cell, with carry-in, carry-out and a valid flag that travels
// alongside the operands.
//
// Optional feature macro: FULL_ADDER_OUTREG_EN
//   defined   -> S, C_out and out_valid come from a 1-cycle output register
//                with synchronous active-high reset on rst.
//   undefined -> purely combinational; clk and rst stay on the port list
//                so instantiations do not change, but nothing uses them.
//
// The port order A, B, C_in, S, C_out comes first so that the classic 1-bit
// full adder can still be instantiated positionally with five ports.
`timescale 1ns/1ps

module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             out_valid
);

    // One full-adder cell: returns {carry_out, sum} for a single bit position.
    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        logic sum_bit;
        logic carry_bit;
        sum_bit   = a ^ b ^ cin;
        carry_bit = (a & b) | (cin & (a ^ b));
        return {carry_bit, sum_bit};
    endfunction

    logic [WIDTH-1:0] sum_comb;
    logic             carry_comb;
    logic             ripple_c;
    logic [1:0]       cell_out;

    // Ripple chain: the carry walks from bit 0 up to bit WIDTH-1, one cell per bit.
    always_comb begin
        sum_comb = '0;
        cell_out = '0;
        ripple_c = C_in;
        for (int i = 0; i < WIDTH; i++) begin
            cell_out    = fa_cell(A[i], B[i], ripple_c);
            sum_comb[i] = cell_out[0];
            ripple_c    = cell_out[1];
        end
        carry_comb = ripple_c;
    end

`ifdef FULL_ADDER_OUTREG_EN

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_out_d;
    logic             c_out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Next-state of the output register is simply this cycle's adder result.
    always_comb begin
        s_d         = sum_comb;
        c_out_d     = carry_comb;
        out_valid_d = in_valid;
    end

    // Free-running output register; an operation captured while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S         = s_q;
    assign C_out     = c_out_q;
    assign out_valid = out_valid_q;

`else

    // clk and rst have no job in the combinational build; folding them into
    // a deliberately unused net keeps the port list identical across builds.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign S         = sum_comb;
    assign C_out     = carry_comb;
    assign out_valid = in_valid;

`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: instantiates full_adder at WIDTH 1, 4 and 8 side by side,
// drives them all from the same operand buses and checks every cycle
// against an arithmetic model (A + B + C_in in WIDTH+1 bits). Works with or
// without FULL_ADDER_OUTREG_EN; in the registered build the model delays its
// answer by one clock edge and clears it on reset.
`timescale 1ns/1ps

module tb_full_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        c_in;
    logic        v_in;

    logic [0:0]  s1;
    logic [3:0]  s4;
    logic [7:0]  s8;
    logic        co1, co4, co8;
    logic        ov1, ov4, ov8;

    int n_compared = 0;
    int n_mismatch = 0;
    bit check_en   = 1'b0;

    // 10 ns clock shared by all three instances.
    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .A(a_in[0:0]), .B(b_in[0:0]), .C_in(c_in), .S(s1), .C_out(co1),
        .clk(clk), .rst(rst), .in_valid(v_in), .out_valid(ov1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .A(a_in[3:0]), .B(b_in[3:0]), .C_in(c_in), .S(s4), .C_out(co4),
        .clk(clk), .rst(rst), .in_valid(v_in), .out_valid(ov4)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .A(a_in[7:0]), .B(b_in[7:0]), .C_in(c_in), .S(s8), .C_out(co8),
        .clk(clk), .rst(rst), .in_valid(v_in), .out_valid(ov8)
    );

    // Instance index -> operand width.
    function automatic int widthOf(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    // Reference: plain unsigned addition of the low w bits; bit w of the result is the carry.
    function automatic logic [64:0] addModel(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic c);
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, c};
    endfunction

    // DUT outputs packed the same way as the model: {C_out, S}.
    function automatic logic [64:0] actTotal(input int k);
        case (k)
            0:       return 65'({co1, s1});
            1:       return 65'({co4, s4});
            default: return 65'({co8, s8});
        endcase
    endfunction

    function automatic logic actValid(input int k);
        case (k)
            0:       return ov1;
            1:       return ov4;
            default: return ov8;
        endcase
    endfunction

`ifdef FULL_ADDER_OUTREG_EN
    logic [64:0] exp_tot_q [3];
    logic        exp_v_q;

    // Registered build: the model remembers what each edge captured, or zero under reset.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            exp_tot_q[k] <= rst ? 65'd0 : addModel(widthOf(k), a_in, b_in, c_in);
        exp_v_q <= rst ? 1'b0 : v_in;
    end

    function automatic logic [64:0] expTotal(input int k);
        return exp_tot_q[k];
    endfunction

    function automatic logic expValid();
        return exp_v_q;
    endfunction
`else
    function automatic logic [64:0] expTotal(input int k);
        return addModel(widthOf(k), a_in, b_in, c_in);
    endfunction

    function automatic logic expValid();
        return v_in;
    endfunction
`endif

    // Every falling edge, once reset has been applied, all three instances must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                n_compared++;
                if (actTotal(k) !== expTotal(k) || actValid(k) !== expValid()) begin
                    n_mismatch++;
                    $display("[TB] FAIL model_w%0d at %0t: got {C_out,S}=%h out_valid=%b, want {C_out,S}=%h out_valid=%b",
                             widthOf(k), $time, actTotal(k), actValid(k), expTotal(k), expValid());
                end
            end
        end
    end

    // Drive a new operation just after a rising edge.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic v, input logic r);
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
        c_in = c;
        v_in = v;
        rst  = r;
    endtask

    // Wait until the operation just applied is visible on the outputs.
    task automatic settle();
`ifdef FULL_ADDER_OUTREG_EN
        @(posedge clk);
        #2;
`else
        #2;
`endif
    endtask

    // Compare one instance against hand-computed literal values.
    task automatic checkOutput(input string name, input int k, input logic [7:0] exp_s,
                               input logic exp_c, input logic exp_v);
        logic [64:0] tot;
        logic [7:0]  act_s;
        logic        act_c;
        logic [7:0]  mask8;
        tot   = actTotal(k);
        mask8 = 8'((16'd1 << widthOf(k)) - 16'd1);
        act_s = tot[7:0] & mask8;
        act_c = tot[widthOf(k)];
        n_compared++;
        if (act_s !== exp_s || act_c !== exp_c || actValid(k) !== exp_v) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got S=%h C_out=%b out_valid=%b, want S=%h C_out=%b out_valid=%b",
                     name, act_s, act_c, actValid(k), exp_s, exp_c, exp_v);
        end
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #100us;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed literal checks first, then a randomized run against the model.
    initial begin
        logic [7:0] sum_tbl;
        logic [7:0] carry_tbl;
        logic [2:0] vec;
        sum_tbl   = 8'b1001_0110;
        carry_tbl = 8'b1110_1000;

        rst  = 1'b1;
        a_in = '0;
        b_in = '0;
        c_in = 1'b0;
        v_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++)
            checkOutput("reset_state", k, 8'h00, 1'b0, 1'b0);
        check_en = 1'b1;

        // Exhaustive single-bit truth table, one vector per clock period.
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            applyStimulus({63'd0, vec[2]}, {63'd0, vec[1]}, vec[0], 1'b1, 1'b0);
            settle();
            checkOutput($sformatf("w1_vec%0d", i), 0, {7'd0, sum_tbl[i]}, carry_tbl[i], 1'b1);
        end

        applyStimulus(64'hF, 64'h1, 1'b0, 1'b1, 1'b0);
        settle();
        checkOutput("w4_ripple_F_1", 1, 8'h0, 1'b1, 1'b1);

        applyStimulus(64'h7, 64'h8, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("w4_ripple_7_8_c", 1, 8'h0, 1'b1, 1'b1);

        applyStimulus(64'hFF, 64'hFF, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("w8_max", 2, 8'hFF, 1'b1, 1'b1);

        applyStimulus(64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        settle();
        checkOutput("w8_zero", 2, 8'h00, 1'b0, 1'b1);

`ifdef FULL_ADDER_OUTREG_EN
        // Latency: the result must appear after the capturing edge and not before.
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        settle();
        applyStimulus(64'h1, 64'h1, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("latency_before_edge", 0, 8'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("latency_after_edge", 0, 8'h0, 1'b1, 1'b1);

        // Reset wins over a valid operation; the next operation lands one cycle later.
        applyStimulus(64'h1, 64'h0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("reset_discard_w1", 0, 8'h0, 1'b0, 1'b0);
        checkOutput("reset_discard_w8", 2, 8'h0, 1'b0, 1'b0);
        applyStimulus(64'h2, 64'h3, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("post_reset_not_yet", 2, 8'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("post_reset_result", 2, 8'h05, 1'b0, 1'b1);
`else
        // Valid pass-through: out_valid tracks in_valid, the sum does not move.
        applyStimulus(64'h5, 64'h3, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("valid_low", 2, 8'h09, 1'b0, 1'b0);
        v_in = 1'b1;
        #2;
        checkOutput("valid_high", 2, 8'h09, 1'b0, 1'b1);
        applyStimulus(64'h5, 64'h3, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("valid_low_again", 2, 8'h09, 1'b0, 1'b0);
`endif

        // Randomized operands, valid and occasional reset; the falling-edge process checks each cycle.
        for (int n = 0; n < 300; n++) begin
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                          1'($urandom), ($urandom_range(0, 19) == 0));
        end
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
